// File: rtl/sha256_w_sched_ctrl.sv
// Message-schedule sequencer for the second pass of double-SHA256: pads a 256-bit
// digest into one block and streams W[0..63] through a 16-word sliding window.
module sha256_w_sched_ctrl (
  input  logic         CLK,
  input  logic         RST,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] digest_in,
  output logic         w_valid,
  input  logic         w_ready,
  output logic [31:0]  w_out,
  output logic [5:0]   round,
  output logic         w_last,
  output logic         busy
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e      state_q, state_d;
  logic [31:0] win_q [16];
  logic [31:0] win_d [16];
  logic [5:0]  round_q, round_d;

  logic        advance;
  logic        last_round;
  logic        fin_adv;
  logic        load;
  logic [31:0] w_new;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Single expander: the new word always lands in win[15] on an advance.
  assign w_new = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

  // Handshake decode; in_ready reopens on the final advance so blocks chain without a bubble.
  always_comb begin
    advance    = (state_q == StRun) && w_ready;
    last_round = (round_q == 6'd63);
    fin_adv    = advance && last_round;
    in_ready   = (state_q == StIdle) || fin_adv;
    load       = in_valid && in_ready;
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      round_q <= 6'd0;
      for (int i = 0; i < 16; i++) begin
        win_q[i] <= 32'h0;
      end
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      for (int i = 0; i < 16; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (fin_adv && !load) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Window and round index next values.
  always_comb begin
    round_d = round_q;
    for (int i = 0; i < 16; i++) begin
      win_d[i] = win_q[i];
    end
    if (load) begin
      for (int i = 0; i < 8; i++) begin
        win_d[i] = digest_in[255-32*i -: 32];
      end
      win_d[8] = 32'h8000_0000;
      for (int i = 9; i < 15; i++) begin
        win_d[i] = 32'h0;
      end
      // Message length of the padded block: 256 bits.
      win_d[15] = 32'h0000_0100;
      round_d   = 6'd0;
    end else if (advance) begin
      for (int i = 0; i < 15; i++) begin
        win_d[i] = win_q[i+1];
      end
      win_d[15] = w_new;
      round_d   = last_round ? 6'd0 : round_q + 6'd1;
    end
  end

  // Outputs are decoded purely from registers.
  always_comb begin
    w_valid = (state_q == StRun);
    busy    = (state_q == StRun);
    w_last  = (state_q == StRun) && (round_q == 6'd63);
    w_out   = win_q[0];
    round   = round_q;
  end

endmodule

// File: doc/sha256_w_sched_ctrl.md
# sha256_w_sched_ctrl

Sequencer for the message schedule of the second SHA-256 pass in double-SHA256. It accepts the 256-bit first-pass digest and builds the fixed-padding 512-bit block internally. It then steps a 16-word window to emit W[0]..W[63], one word per handshake, to the round datapath. It sits between the first-pass hash output and the second-pass compression pipeline, and owns load/advance sequencing and backpressure for the expander.

## Interface
- No parameters. Widths fixed: 32-bit words, 256-bit digest, 6-bit round index.
- CLK  in  1  single clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- in_valid  in  1  digest_in valid
- in_ready  out  1  block accepts a digest this cycle
- digest_in  in  256  first-pass digest; D0 = [255:224] … D7 = [31:0]
- w_valid  out  1  w_out holds W[round]
- w_ready  in  1  consumer takes w_out this cycle
- w_out  out  32  current schedule word
- round  out  6  index t of w_out (0..63)
- w_last  out  1  high while round==63 and w_valid
- busy  out  1  high in RUN

## Operation
- FSM states: IDLE, RUN.
- IDLE: in_ready=1, w_valid=0.
  - On in_valid: load window win[0..15] = {D0..D7, 32'h80000000, 6×32'h0, 32'h00000100}; round←0; go to RUN.
- RUN: w_valid=1, w_out=win[0].
  - Without w_ready: hold all state; w_out and round stay stable.
  - On w_ready (advance): win[i]←win[i+1] for i=0..14; win[15]←σ1(win[14]) + win[9] + σ0(win[1]) + win[0] (mod 2^32); round←round+1.
- σ0(x) = ROTR7 ^ ROTR18 ^ SHR3. σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
- Completion: an advance with round==63 returns the FSM to IDLE. Words generated past W[63] are discarded; round does not wrap to 0 inside RUN.
- Back-to-back: in_ready = (state==IDLE) | (round==63 & w_ready).
  - If in_valid is also high on that final advance, the new digest loads, round←0, and the FSM stays in RUN with no bubble.
- in_valid while in RUN and not on the final advance: ignored (in_ready=0). The digest is not captured.
- Window: 16×32-bit registers; one new word per advance. Single σ0/σ1/adder tree; no per-round duplication.

## Timing
- Reset: state=IDLE, window=0, round=0, w_valid=0, w_last=0, busy=0, w_out=0, in_ready=1 the cycle after RST is sampled high.
- RST has priority over any handshake in the same cycle. Reset mid-block abandons the block; no further words are emitted.
- Load latency: digest accepted at edge k → w_valid=1 with W[0]=D0 from cycle k+1.
- Throughput: one word per cycle while w_ready=1. A block takes exactly 64 accepted handshakes; 64 cycles minimum.
- in_ready depends combinationally on w_ready. w_valid, w_out, round and w_last are register outputs with no combinational path from inputs.
- w_valid never drops while in RUN, whatever w_ready does (AXI-stream rule).

## Test plan
- Reset/idle: assert RST 2 cycles mid-block → next cycle w_valid=0, round=0, w_out=0, in_ready=1.
- Zero digest, w_ready=1:
  - W[0..7]=0, W[8]=0x80000000, W[9..14]=0, W[15]=0x00000100.
  - W[16]=0x00000000, W[17]=0x00A00000.
  - w_last only on round 63; 64 words total; then IDLE.
- D0=0x00000001, D1=0x00000001, others 0 → W[16]=0x02004001.
  - Full 64-word stream matches a software SHA-256 schedule model for 100 random digests.
- Backpressure: random w_ready at 30% duty → w_out/round stable while stalled; the word sequence is identical to the no-stall run.
- Back-to-back: second digest held valid during block 1 → accepted exactly on the round-63 advance. Block 2 W[0] appears the next cycle with no w_valid gap.
- in_valid pulsed during rounds 10–20 → not accepted (in_ready=0); the block 1 stream is unaffected.
